// File: rtl/injector_pulse_scheduler.sv
// Injector pulse scheduler: crank-angle triggered, tick-timed enables.
// Feeds the injector driver's 4-bit enable vector.
//
// Ports:
//   i_clock, i_reset      clock, async active-high reset
//   i_tick                1-cycle timebase strobe, counts pulse width
//   i_crankAngle          crank angle in 0.5 deg units (0..1439)
//   i_angleValid          angle trustworthy; gates new starts only
//   i_fuelCut             level; kills running pulses, blocks starts
//   i_cfgWrite            loads shadow start/width of i_cfgChannel
//   i_cfgChannel          config target channel
//   i_cfgStartAngle       start angle to store (>1439 never matches)
//   i_cfgPulseWidth       width in ticks, clamped to MAX_PW
//   i_errClear            clears o_overlapErr (a new overlap wins)
//   o_enable              per-channel injector enable
//   o_overlapErr          sticky: start event hit an active channel
module injector_pulse_scheduler #(
  parameter int CHANNELS  = 4,
  parameter int ANGLE_W   = 11,
  parameter int PW_W      = 16,
  parameter int MAX_PW    = 20000,
  parameter int ANGLE_MAX = 1439
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_tick,
  input  logic [ANGLE_W-1:0]  i_crankAngle,
  input  logic                i_angleValid,
  input  logic                i_fuelCut,
  input  logic                i_cfgWrite,
  input  logic [1:0]          i_cfgChannel,
  input  logic [ANGLE_W-1:0]  i_cfgStartAngle,
  input  logic [PW_W-1:0]     i_cfgPulseWidth,
  input  logic                i_errClear,
  output logic [CHANNELS-1:0] o_enable,
  output logic [CHANNELS-1:0] o_overlapErr
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } ch_state_t;

  localparam logic [PW_W-1:0]    PW_CLAMP  = PW_W'(MAX_PW);
  localparam logic [ANGLE_W-1:0] ANGLE_TOP = ANGLE_W'(ANGLE_MAX);

  ch_state_t             state_q [CHANNELS];
  ch_state_t             state_d [CHANNELS];
  logic [PW_W-1:0]       cnt_q   [CHANNELS];
  logic [PW_W-1:0]       cnt_d   [CHANNELS];
  logic [ANGLE_W-1:0]    start_q [CHANNELS];
  logic [PW_W-1:0]       width_q [CHANNELS];
  logic [ANGLE_W-1:0]    prev_angle;
  logic [PW_W-1:0]       width_clamped;
  logic [CHANNELS-1:0]   start_evt;
  logic [CHANNELS-1:0]   overlap;
  logic [CHANNELS-1:0]   err_q;
  logic [CHANNELS-1:0]   err_d;

  assign width_clamped = (i_cfgPulseWidth > PW_CLAMP)
                         ? PW_CLAMP : i_cfgPulseWidth;

  // Shadow config. A start in the write cycle still sees the old
  // values because this register only updates on the edge.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        start_q[c] <= '0;
        width_q[c] <= '0;
      end
    end else if (i_cfgWrite) begin
      start_q[i_cfgChannel] <= i_cfgStartAngle;
      width_q[i_cfgChannel] <= width_clamped;
    end
  end

  // Previous angle tracks even while the angle is invalid, so a
  // dwell on the start angle cannot look like a fresh edge later.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      prev_angle <= '0;
    end else begin
      prev_angle <= i_crankAngle;
    end
  end

  // Match edge: angle equals start now but did not last cycle.
  always_comb begin
    start_evt = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      start_evt[c] = i_angleValid
                   && !i_fuelCut
                   && (start_q[c] <= ANGLE_TOP)
                   && (i_crankAngle == start_q[c])
                   && (prev_angle != start_q[c])
                   && (width_q[c] != '0);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= IDLE;
        cnt_q[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
    end
  end

  always_comb begin
    overlap = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      unique case (state_q[c])
        IDLE: begin
          if (start_evt[c]) begin
            state_d[c] = ACTIVE;
            cnt_d[c]   = width_q[c];
          end
        end
        ACTIVE: begin
          overlap[c] = start_evt[c];
          if (i_fuelCut) begin
            state_d[c] = IDLE;
            cnt_d[c]   = '0;
          end else if (i_tick) begin
            // <=1 also recovers from a stray zero count.
            if (cnt_q[c] <= PW_W'(1)) begin
              state_d[c] = IDLE;
              cnt_d[c]   = '0;
            end else begin
              cnt_d[c] = cnt_q[c] - PW_W'(1);
            end
          end
        end
        default: begin
          state_d[c] = IDLE;
          cnt_d[c]   = '0;
        end
      endcase
    end
  end

  // A new overlap in the clear cycle keeps the flag set.
  assign err_d = overlap | (i_errClear ? '0 : err_q);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  always_comb begin
    o_enable = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      o_enable[c] = (state_q[c] == ACTIVE);
    end
  end

  assign o_overlapErr = err_q;

endmodule

// File: tb/tb_injector_pulse_scheduler.sv
// Bench for injector_pulse_scheduler: directed scenarios plus a
// random run, checked against a tick-deadline reference model.
module tb_injector_pulse_scheduler;

  localparam int AW    = 11;
  localparam int PWW   = 16;
  localparam int MAXPW = 20000;

  logic           clk = 1'b0;
  logic           rst;
  logic           tick;
  logic [AW-1:0]  angle;
  logic           valid;
  logic           fuel;
  logic           cfg_wr;
  logic [1:0]     cfg_ch;
  logic [AW-1:0]  cfg_start;
  logic [PWW-1:0] cfg_pw;
  logic           err_clr;
  logic [3:0]     en;
  logic [3:0]     err;

  injector_pulse_scheduler dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_tick          (tick),
    .i_crankAngle    (angle),
    .i_angleValid    (valid),
    .i_fuelCut       (fuel),
    .i_cfgWrite      (cfg_wr),
    .i_cfgChannel    (cfg_ch),
    .i_cfgStartAngle (cfg_start),
    .i_cfgPulseWidth (cfg_pw),
    .i_errClear      (err_clr),
    .o_enable        (en),
    .o_overlapErr    (err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: a pulse ends when the global tick count reaches
  // the deadline fixed at the start event.
  int     m_start [4];
  int     m_pw    [4];
  bit     m_act   [4];
  longint m_dead  [4];
  bit     m_err   [4];
  int     m_prev;
  longint m_ticks;

  int   cyc;
  int   tick_div;
  bit   tick_rand;
  int   hi_ticks [4];
  int   rises    [4];
  logic [3:0] en_prev;

  function automatic logic [3:0] m_env();
    logic [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = m_act[c];
    return v;
  endfunction

  function automatic logic [3:0] m_errv();
    logic [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = m_err[c];
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_start[c] = 0;
      m_pw[c]    = 0;
      m_act[c]   = 0;
      m_dead[c]  = 0;
      m_err[c]   = 0;
    end
    m_prev  = 0;
    m_ticks = 0;
  endtask

  task automatic model_cycle();
    bit     evt;
    bit     was;
    longint tn;
    tn = m_ticks + (tick ? 1 : 0);
    for (int c = 0; c < 4; c++) begin
      evt = valid && !fuel && m_start[c] <= 1439
            && int'(angle) == m_start[c]
            && m_prev != m_start[c] && m_pw[c] != 0;
      was = m_act[c];
      if (was) begin
        if (fuel || tn >= m_dead[c]) m_act[c] = 0;
      end else if (evt) begin
        m_act[c]  = 1;
        m_dead[c] = tn + m_pw[c];
      end
      if (evt && was) m_err[c] = 1;
      else if (err_clr) m_err[c] = 0;
    end
    m_ticks = tn;
    if (cfg_wr) begin
      m_start[cfg_ch] = int'(cfg_start);
      m_pw[cfg_ch]    = (int'(cfg_pw) > MAXPW) ? MAXPW : int'(cfg_pw);
    end
    m_prev = int'(angle);
  endtask

  task automatic step();
    if (tick_rand) tick = ($urandom_range(2) == 0);
    else if (tick_div > 0) tick = (cyc % tick_div == 0);
    else tick = 1'b0;
    if (rst) model_reset();
    else model_cycle();
    for (int c = 0; c < 4; c++)
      if (en[c] && tick) hi_ticks[c]++;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++)
      if (en[c] && !en_prev[c]) rises[c]++;
    en_prev = en;
    cyc++;
    cfg_wr  = 1'b0;
    err_clr = 1'b0;
  endtask

  // Steps n cycles; counts cycles where outputs disagree with model.
  task automatic run(input int n, output int bad, output string info);
    bad  = 0;
    info = "";
    for (int i = 0; i < n; i++) begin
      step();
      if (en !== m_env() || err !== m_errv()) begin
        if (bad == 0)
          info = $sformatf("cyc=%0d en=%b/%b err=%b/%b",
                           cyc, en, m_env(), err, m_errv());
        bad++;
      end
    end
  endtask

  task automatic clear_stats();
    for (int c = 0; c < 4; c++) begin
      hi_ticks[c] = 0;
      rises[c]    = 0;
    end
  endtask

  task automatic cfg(input int ch, input int s, input int w);
    cfg_wr    = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_start = AW'(s);
    cfg_pw    = PWW'(w);
    step();
  endtask

  task automatic go(input int a);
    angle = AW'(a);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst     = 1'b0;
    angle   = '0;
    valid   = 1'b0;
    fuel    = 1'b0;
    cfg_wr  = 1'b0;
    err_clr = 1'b0;
    tick_rand = 0;
    clear_stats();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (en !== 4'b0 || err !== 4'b0)
      $display("FAIL reset en=%b err=%b exp 0000/0000", en, err);
    else passed++;
  endtask

  task automatic test_basic();
    int bad; string info;
    do_reset();
    tick_div = 10;
    cfg(0, 100, 50);
    valid = 1'b1;
    go(98);
    go(99);
    go(100);
    total++;
    if (en !== 4'b0001)
      $display("FAIL basic_rise en=%b exp 0001", en);
    else passed++;
    angle = AW'(101);
    run(600, bad, info);
    total++;
    if (bad != 0) $display("FAIL basic_trace %0d bad, %s", bad, info);
    else passed++;
    total++;
    if (hi_ticks[0] != 50 || rises[0] != 1 || en !== 4'b0)
      $display("FAIL basic_len ticks=%0d rises=%0d en=%b exp 50/1/0000",
               hi_ticks[0], rises[0], en);
    else passed++;
  endtask

  task automatic test_dwell();
    int bad; string info;
    do_reset();
    tick_div = 10;
    cfg(0, 100, 50);
    valid = 1'b1;
    go(99);
    angle = AW'(100);
    run(2000, bad, info);
    total++;
    if (bad != 0) $display("FAIL dwell_trace %0d bad, %s", bad, info);
    else passed++;
    total++;
    if (rises[0] != 1 || err !== 4'b0 || hi_ticks[0] != 50)
      $display("FAIL dwell_once rises=%0d err=%b ticks=%0d exp 1/0000/50",
               rises[0], err, hi_ticks[0]);
    else passed++;
  endtask

  task automatic test_overlap();
    int bad; string info;
    do_reset();
    tick_div = 2;
    cfg(1, 200, 1000);
    valid = 1'b1;
    go(199);
    go(200);
    angle = AW'(201);
    run(100, bad, info);
    go(200);
    angle = AW'(201);
    total++;
    if (err !== 4'b0010 || en !== 4'b0010)
      $display("FAIL ovl_set err=%b en=%b exp 0010/0010", err, en);
    else passed++;
    run(2200, bad, info);
    total++;
    if (bad != 0 || hi_ticks[1] != 1000 || err !== 4'b0010)
      $display("FAIL ovl_len bad=%0d ticks=%0d err=%b exp 0/1000/0010 %s",
               bad, hi_ticks[1], err, info);
    else passed++;
    err_clr = 1'b1;
    step();
    total++;
    if (err !== 4'b0)
      $display("FAIL ovl_clear err=%b exp 0000", err);
    else passed++;
    go(200);
    angle = AW'(201);
    run(10, bad, info);
    err_clr = 1'b1;
    go(200);
    total++;
    if (err !== 4'b0010)
      $display("FAIL ovl_set_wins err=%b exp 0010", err);
    else passed++;
    angle = AW'(201);
    err_clr = 1'b1;
    run(2100, bad, info);
    total++;
    if (bad != 0 || en !== 4'b0 || err !== 4'b0)
      $display("FAIL ovl_tail bad=%0d en=%b err=%b %s", bad, en, err, info);
    else passed++;
  endtask

  task automatic test_fuelcut();
    int bad; string info; int n;
    do_reset();
    tick_div = 1;
    cfg(2, 300, 500);
    valid = 1'b1;
    go(299);
    go(300);
    angle = AW'(301);
    n = 0;
    while (hi_ticks[2] < 100 && n < 1000) begin
      step();
      n++;
    end
    total++;
    if (hi_ticks[2] < 100)
      $display("FAIL fuel_wait ticks=%0d exp 100", hi_ticks[2]);
    else passed++;
    fuel = 1'b1;
    step();
    total++;
    if (en[2] !== 1'b0)
      $display("FAIL fuel_cut en=%b exp 0000", en);
    else passed++;
    run(20, bad, info);
    fuel = 1'b0;
    clear_stats();
    go(299);
    go(300);
    angle = AW'(301);
    run(600, bad, info);
    total++;
    if (bad != 0 || hi_ticks[2] != 500 || rises[2] != 1)
      $display("FAIL fuel_refire bad=%0d ticks=%0d rises=%0d %s",
               bad, hi_ticks[2], rises[2], info);
    else passed++;
  endtask

  task automatic test_cfg_active();
    int bad; string info;
    do_reset();
    tick_div = 1;
    cfg(3, 400, 200);
    valid = 1'b1;
    go(399);
    go(400);
    angle = AW'(401);
    run(50, bad, info);
    cfg(3, 400, 300);
    run(300, bad, info);
    total++;
    if (bad != 0 || hi_ticks[3] != 200)
      $display("FAIL cfg_cur bad=%0d ticks=%0d exp 200 %s",
               bad, hi_ticks[3], info);
    else passed++;
    clear_stats();
    go(399);
    go(400);
    angle = AW'(401);
    run(400, bad, info);
    total++;
    if (bad != 0 || hi_ticks[3] != 300)
      $display("FAIL cfg_next bad=%0d ticks=%0d exp 300 %s",
               bad, hi_ticks[3], info);
    else passed++;
    cfg(3, 400, 30000);
    clear_stats();
    go(399);
    go(400);
    angle = AW'(401);
    run(20100, bad, info);
    total++;
    if (bad != 0 || hi_ticks[3] != MAXPW)
      $display("FAIL cfg_clamp bad=%0d ticks=%0d exp %0d %s",
               bad, hi_ticks[3], MAXPW, info);
    else passed++;
  endtask

  task automatic test_same_cycle();
    int bad; string info;
    do_reset();
    tick_div = 1;
    cfg(0, 500, 40);
    valid = 1'b1;
    go(499);
    cfg_wr = 1'b1;
    cfg_ch = 2'd0;
    cfg_start = AW'(500);
    cfg_pw = PWW'(80);
    go(500);
    angle = AW'(501);
    run(100, bad, info);
    total++;
    if (bad != 0 || hi_ticks[0] != 40)
      $display("FAIL same_old bad=%0d ticks=%0d exp 40 %s",
               bad, hi_ticks[0], info);
    else passed++;
    clear_stats();
    go(500);
    angle = AW'(501);
    run(120, bad, info);
    total++;
    if (bad != 0 || hi_ticks[0] != 80)
      $display("FAIL same_new bad=%0d ticks=%0d exp 80 %s",
               bad, hi_ticks[0], info);
    else passed++;
  endtask

  task automatic test_boundary();
    int bad; string info;
    do_reset();
    tick_div = 1;
    cfg(0, 0, 10);
    cfg(1, 1500, 10);
    cfg(2, 10, 10);
    cfg(3, 20, 0);
    valid = 1'b1;
    go(1438);
    go(1439);
    go(0);
    total++;
    if (en !== 4'b0001)
      $display("FAIL wrap_fire en=%b exp 0001", en);
    else passed++;
    go(1499);
    go(1500);
    go(1501);
    valid = 1'b0;
    go(9);
    go(10);
    go(11);
    valid = 1'b1;
    go(19);
    go(20);
    angle = AW'(21);
    run(30, bad, info);
    total++;
    if (bad != 0 || rises[1] != 0 || rises[2] != 0 || rises[3] != 0)
      $display("FAIL no_fire bad=%0d rises=%0d/%0d/%0d %s",
               bad, rises[1], rises[2], rises[3], info);
    else passed++;
  endtask

  task automatic test_random();
    int bad; int tb; string info; int a;
    do_reset();
    tick_rand = 1;
    valid = 1'b1;
    a = 0;
    tb = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(15) == 0) begin
        cfg_wr    = 1'b1;
        cfg_ch    = 2'($urandom_range(3));
        cfg_start = AW'($urandom_range(63));
        cfg_pw    = ($urandom_range(7) == 0) ? '0
                    : PWW'($urandom_range(60, 1));
      end
      a = (a + int'($urandom_range(3)) + 63) % 64;
      angle   = AW'(a);
      valid   = ($urandom_range(9) != 0);
      fuel    = ($urandom_range(49) == 0);
      err_clr = ($urandom_range(19) == 0);
      run(1, bad, info);
      tb += bad;
      if (bad != 0 && tb == 1)
        $display("FAIL rand_cycle %s", info);
    end
    fuel = 1'b0;
    tick_rand = 0;
    total++;
    if (tb != 0) $display("FAIL rand_trace %0d bad cycles", tb);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int bad; string info;
    do_reset();
    tick_div = 1;
    for (int c = 0; c < 4; c++) cfg(c, 600 + 2 * c, 1000);
    valid = 1'b1;
    for (int a = 599; a <= 607; a++) go(a);
    total++;
    if (en !== 4'b1111)
      $display("FAIL mid_all en=%b exp 1111", en);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if (en !== 4'b0 || err !== 4'b0)
      $display("FAIL mid_async en=%b err=%b exp 0000/0000", en, err);
    else passed++;
    step();
    step();
    rst = 1'b0;
    clear_stats();
    for (int a = 590; a <= 620; a++) go(a);
    for (int a = 0; a <= 30; a++) go(a);
    run(50, bad, info);
    total++;
    if (bad != 0 || en !== 4'b0 ||
        rises[0] + rises[1] + rises[2] + rises[3] != 0)
      $display("FAIL mid_rearm bad=%0d en=%b %s", bad, en, info);
    else passed++;
  endtask

  initial begin
    rst       = 1'b1;
    tick      = 1'b0;
    angle     = '0;
    valid     = 1'b0;
    fuel      = 1'b0;
    cfg_wr    = 1'b0;
    cfg_ch    = '0;
    cfg_start = '0;
    cfg_pw    = '0;
    err_clr   = 1'b0;
    cyc       = 0;
    tick_div  = 0;
    tick_rand = 0;
    en_prev   = '0;
    model_reset();
    clear_stats();
    test_reset();
    test_basic();
    test_dwell();
    test_overlap();
    test_fuelcut();
    test_cfg_active();
    test_same_cycle();
    test_boundary();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/injector_pulse_scheduler.md
Name: injector_pulse_scheduler

Overview:
Upstream stage of the injector driver subsystem. Converts crank-angle position plus per-channel start-angle and pulse-width configuration into the 4-bit injector enable vector consumed by the injector driver (its i_enable input). Each channel fires once when the crank angle reaches its start angle and holds enable for a time-based pulse width counted in timebase ticks. Configuration is double-buffered so in-flight pulses are never disturbed.

Parameters:
CHANNELS, 4, number of injector channels (the injector driver is 4 wide)
ANGLE_W, 11, crank-angle width; 0.5° units, valid range 0..1439 (720° cycle)
PW_W, 16, pulse-width counter width, in i_tick units
MAX_PW, 20000, pulse-width clamp in ticks

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous reset, active-high
i_tick  in  1  1-cycle timebase strobe (1 µs nominal)
i_crankAngle  in  ANGLE_W  current crank angle
i_angleValid  in  1  crank decoder synchronised; angle trustworthy
i_fuelCut  in  1  global fuel cut, level
i_cfgWrite  in  1  1-cycle config write strobe
i_cfgChannel  in  2  target channel for config write
i_cfgStartAngle  in  ANGLE_W  start angle for write
i_cfgPulseWidth  in  PW_W  pulse width for write
i_errClear  in  1  clears o_overlapErr
o_enable  out  CHANNELS  injector enable to the driver, one bit per channel
o_overlapErr  out  CHANNELS  sticky: a start event hit an already-active channel

Behaviour:
- One clock domain, one clock; reset is asynchronous and active-high. On reset: o_enable=0, o_overlapErr=0, all shadow/active registers=0, all channels IDLE, previous-angle register=0.
- Config: i_cfgWrite loads the shadow start/width of i_cfgChannel in the next cycle. Start angles >1439 are stored but never match. Pulse width is clamped to MAX_PW on write.
- Start event (channel c, cycle N): i_angleValid=1, i_crankAngle==shadowStart[c], previous-cycle angle != shadowStart[c] (match edge only, no refire while the angle dwells), shadowPW[c]!=0, i_fuelCut=0.
- Per-channel FSM, 2 states:
  - IDLE -> ACTIVE on a start event. Active counter loads shadowPW[c]. o_enable[c]=1 from cycle N+1 (1-cycle latency).
  - ACTIVE: the counter decrements on each i_tick. An i_tick in cycle N itself is not counted. When the counter reaches 0, o_enable[c] drops in the next cycle and the channel returns to IDLE. Pulse length is exactly PW ticks (±1 clock).
  - ACTIVE -> IDLE immediately (o_enable[c]=0 the next cycle) when i_fuelCut=1. The counter is cleared.
- Start event while ACTIVE: ignored, pulse not extended, o_overlapErr[c] set.
- Simultaneous i_cfgWrite to channel c and start event on c: the start uses the pre-write shadow values. The new values apply to the next event.
- Config write to an ACTIVE channel: updates shadow only. The running pulse is unaffected.
- i_angleValid low: no new starts. Running pulses finish on time. The previous-angle register still updates.
- i_errClear and a new overlap in the same cycle: set wins.
- Wrap-around: the angle going 1439->0 is treated as a normal change. Start angle 0 fires on the wrap.
- Multiple channels may be active concurrently. There is no arbitration.
- Reset mid-pulse: o_enable drops asynchronously. The channel re-arms only on a fresh match edge after release.

Test Plan:
- Reset, write ch0 start=100 PW=50, sweep the angle 98,99,100,101 with i_tick every 10 clocks -> o_enable[0] rises the cycle after angle=100 and stays high for 50 ticks (~500 clocks), then falls; other bits stay 0.
- Angle held at 100 for 2000 clocks with PW=50 -> exactly one pulse, no refire, o_overlapErr=0.
- ch1 PW=1000 active, angle re-reaches start mid-pulse -> pulse not extended, o_overlapErr[1]=1 until i_errClear pulses.
- ch2 active with PW=500, i_fuelCut asserted after 100 ticks -> o_enable[2]=0 the next cycle. Later match with i_fuelCut=0 fires a full 500-tick pulse.
- Write ch3 PW=300 during an active 200-tick pulse -> current pulse is 200 ticks, next is 300. Write PW=30000 -> pulse is 20000 ticks.
- Assert i_reset mid-pulse on all channels -> o_enable=0 immediately. PW=0 on every channel after release, so no pulses until reconfigured.
